mipi_dly_tap_cal: RTL and testbench
===================================

// Module: mipi_dly_tap_cal
// PURPOSE
//  Runtime calibration controller for a tapped DELAY_BUF chain on the MIPI RX byte path.
//  Sweeps tap_sel across every tap and, at each tap, counts HS sync-byte hits in the received data.
//  Then selects the centre of the longest passing run and holds it for the datapath mux.
//  Sits between the RX byte aligner (data source) and the delay-chain tap mux (tap_sel sink).
// PARAMETERS
//  NUM_TAPS     8      number of selectable delay taps (2..16)
//  TAP_W        3      width of tap_sel; must satisfy 2**TAP_W >= NUM_TAPS
//  DEFAULT_TAP  4      tap driven out of reset and after a failed calibration
//  SETTLE_CYC   16     cycles waited after each tap change before counting starts
//  WIN_CYC      256    clk cycles in the measurement window per tap
//  MIN_HITS     4      sync hits in one window needed to mark a tap as passing
//  SYNC_BYTE    8'hB8  MIPI HS sync pattern
// PORTS
//  clk        in   1           byte clock; all logic is on the rising edge
//  rst        in   1           asynchronous, active-high reset
//  cal_start  in   1           one-cycle request to start a calibration sweep
//  data_in    in   8           received byte, sampled through the current tap
//  data_vld   in   1           data_in is valid this cycle
//  tap_sel    out  TAP_W       delay tap select for the chain mux
//  cal_busy   out  1           high while a sweep or evaluation is in progress
//  cal_done   out  1           one-cycle pulse at the end of a calibration
//  cal_fail   out  1           sticky flag: the last calibration found no passing tap
//  pass_map   out  NUM_TAPS    per-tap pass bitmap (present only with MIPI_DLY_CAL_MAP_EN)
// BEHAVIOUR
//  Reset values: tap_sel=DEFAULT_TAP, cal_busy=0, cal_done=0, cal_fail=0, pass_map=0, FSM=IDLE.
//  FSM states: IDLE -> SETTLE -> MEASURE -> NEXT -> (SETTLE | EVAL) -> DONE -> IDLE.
//  IDLE: when cal_start=1, set tap_sel=0, clear the bitmap, and go to SETTLE. cal_busy rises the next cycle.
//  SETTLE: count SETTLE_CYC cycles. data_in is ignored.
//  MEASURE: count WIN_CYC cycles. hit counter increments when data_vld && data_in==SYNC_BYTE.
//   The hit counter saturates at MIN_HITS.
//  NEXT: set pass[tap] = (hits==MIN_HITS) and clear hits.
//   If tap==NUM_TAPS-1, go to EVAL; otherwise tap_sel+=1 and go to SETTLE.
//  EVAL: scan the bitmap one tap per cycle (NUM_TAPS cycles) to find the longest contiguous run of 1s.
//   On equal lengths, the lowest start index wins. There is no wrap-around between tap NUM_TAPS-1 and tap 0.
//   Result tap = start + (len-1)>>1, which rounds toward the lower tap.
//   If len==0, result tap = DEFAULT_TAP and cal_fail is set to 1.
//  DONE: drive tap_sel = result tap, pulse cal_done for one cycle, drop cal_busy, return to IDLE.
//   cal_fail is cleared only by a later successful calibration or by rst.
//  Latency from cal_start to cal_done: NUM_TAPS*(SETTLE_CYC+WIN_CYC+1) + NUM_TAPS + 2 cycles.
//  cal_start while cal_busy=1 is ignored; it is not queued.
//  cal_start in the same cycle as the DONE state is ignored; a new sweep needs cal_start in IDLE.
//  rst mid-operation: immediate return to reset values; the partial bitmap is discarded.
// CONFIGURATION
//  MIPI_DLY_CAL_MAP_EN defined: pass_map port exists. It updates at DONE and holds until the next DONE or rst.
//  MIPI_DLY_CAL_MAP_EN undefined: no pass_map port. The bitmap stays internal; all other behaviour is identical.
// STRUCTURE
//  Shared package mipi_dly_pkg holds:
//   - FSM state enum typedef (IDLE, SETTLE, MEASURE, NEXT, EVAL, DONE)
//   - SYNC_BYTE constant
//   - the tap-select width function clog2(NUM_TAPS)
//  One sub-module, mipi_dly_run_finder, implements the sequential longest-run scan in EVAL:
//   - inputs: start pulse, bitmap
//   - outputs: best_start, best_len, valid
//  Counters, hit detection and the FSM stay in the top module.
// TESTING  (NUM_TAPS=8, SETTLE_CYC=16, WIN_CYC=256, MIN_HITS=4)
//  Reset: assert rst -> tap_sel=4, cal_busy=0, cal_done=0, cal_fail=0, pass_map=8'h00.
//  Centre pick: sync bytes only on taps 2..5 -> tap_sel=3, pass_map=8'b0011_1100, cal_fail=0.
//   cal_done pulses once, exactly 2194 cycles after cal_start.
//  No eye: no SYNC_BYTE on any tap -> cal_fail=1, tap_sel=4, pass_map=8'h00.
//   A later pass on taps 6..7 -> tap_sel=6, cal_fail=0.
//  Longest run: taps 0..1 and 5..7 pass -> tap_sel=6.
//   Tie case: taps 0..1 and 4..5 pass -> tap_sel=0.
//  Threshold: tap 3 gets 3 hits, all other taps get 0 -> tap fails, cal_fail=1.
//   Tap 3 gets 4 hits, all other taps get 0 -> tap_sel=3.
//  Robustness: cal_start during MEASURE at tap 3 has no effect, and the sweep completes normally.
//   rst asserted mid-MEASURE -> next cycle tap_sel=4, cal_busy=0, and no cal_done pulse.

Source files
------------

// File: rtl/mipi_dly_pkg.sv
// Shared definitions for the MIPI RX delay-tap calibration controller:
// FSM state encoding, the HS sync pattern and a width helper.
package mipi_dly_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        NEXT,
        EVAL,
        DONE
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // Bits needed to encode n distinct values (minimum 1).
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w = w + 1;
        if (w == 0) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/mipi_dly_run_finder.sv
// Sequential longest-run scanner for the per-tap pass bitmap.
// One bit per cycle, starting with the cycle in which start is high. valid
// pulses once after the last tap. The earliest run wins ties, and there is no
// wrap-around from the top tap to tap 0.
module mipi_dly_run_finder
    import mipi_dly_pkg::*;
#(
    parameter int NUM_TAPS = 8,
    parameter int TAP_W    = 3,
    parameter int LEN_W    = clog2(NUM_TAPS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_TAPS-1:0] bitmap,
    output logic [TAP_W-1:0]    best_start,
    output logic [LEN_W-1:0]    best_len,
    output logic                valid
);

    logic [TAP_W-1:0] idx;
    logic [TAP_W-1:0] run_start;
    logic [LEN_W-1:0] run_len;
    logic             active;

    logic [TAP_W-1:0] cur_idx;
    logic [LEN_W-1:0] prev_len;
    logic [LEN_W-1:0] prev_best;
    logic [LEN_W-1:0] new_len;
    logic [TAP_W-1:0] new_start;

    // Step the run tracker by one bitmap position; start restarts from tap 0.
    always_comb begin
        cur_idx   = start ? '0 : idx;
        prev_len  = start ? '0 : run_len;
        prev_best = start ? '0 : best_len;
        new_len   = bitmap[cur_idx] ? prev_len + LEN_W'(1) : '0;
        new_start = (prev_len == '0) ? cur_idx : run_start;
    end

    // Scan registers: only a strictly longer run replaces the best, so ties keep the lower start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            active     <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start || active) begin
                run_len   <= new_len;
                run_start <= new_start;
                idx       <= cur_idx + TAP_W'(1);
                if (new_len > prev_best) begin
                    best_len   <= new_len;
                    best_start <= new_start;
                end else if (start) begin
                    best_len   <= '0;
                    best_start <= '0;
                end
                if (cur_idx == TAP_W'(NUM_TAPS - 1)) begin
                    active <= 1'b0;
                    valid  <= 1'b1;
                end else begin
                    active <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mipi_dly_tap_cal.sv
// Runtime delay-tap calibration for the MIPI RX byte path. Each tap is swept
// in turn: the chain settles, then HS sync bytes are counted over a window.
// The centre of the longest passing run then drives tap_sel.
// Optional feature: define MIPI_DLY_CAL_MAP_EN to expose the pass bitmap on pass_map.
module mipi_dly_tap_cal
    import mipi_dly_pkg::*;
#(
    parameter int         NUM_TAPS    = 8,
    parameter int         TAP_W       = 3,
    parameter int         DEFAULT_TAP = 4,
    parameter int         SETTLE_CYC  = 16,
    parameter int         WIN_CYC     = 256,
    parameter int         MIN_HITS    = 4,
    parameter logic [7:0] SYNC_BYTE   = mipi_dly_pkg::SYNC_BYTE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cal_start,
    input  logic [7:0]          data_in,
    input  logic                data_vld,
    output logic [TAP_W-1:0]    tap_sel,
    output logic                cal_busy,
    output logic                cal_done,
    output logic                cal_fail
`ifdef MIPI_DLY_CAL_MAP_EN
    ,
    output logic [NUM_TAPS-1:0] pass_map
`endif
);

    localparam int MAX_CYC = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
    localparam int CNT_W   = clog2(MAX_CYC);
    localparam int HIT_W   = clog2(MIN_HITS + 1);
    localparam int LEN_W   = clog2(NUM_TAPS + 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [HIT_W-1:0]    hits;
    logic [NUM_TAPS-1:0] bitmap;
    logic                eval_go;

    logic                settle_end;
    logic                win_end;
    logic                last_tap;
    logic                hit;

    logic [TAP_W-1:0]    fin_start;
    logic [LEN_W-1:0]    fin_len;
    logic                fin_valid;
    logic [LEN_W-1:0]    half_len;
    logic [TAP_W-1:0]    result_tap;

    assign settle_end = (cnt == CNT_W'(SETTLE_CYC - 1));
    assign win_end    = (cnt == CNT_W'(WIN_CYC - 1));
    assign last_tap   = (tap_sel == TAP_W'(NUM_TAPS - 1));
    assign hit        = data_vld && (data_in == SYNC_BYTE);

    // Centre of the best run, rounded toward the lower tap.
    assign half_len   = (fin_len - LEN_W'(1)) >> 1;
    assign result_tap = fin_start + TAP_W'(half_len);

    mipi_dly_run_finder #(
        .NUM_TAPS (NUM_TAPS),
        .TAP_W    (TAP_W),
        .LEN_W    (LEN_W)
    ) u_run_finder (
        .clk        (clk),
        .rst        (rst),
        .start      (eval_go),
        .bitmap     (bitmap),
        .best_start (fin_start),
        .best_len   (fin_len),
        .valid      (fin_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; cal_start is only honoured in IDLE.
    always_comb begin
        // NOTE: assigning the default before the case keeps every path driven, so no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (cal_start)  state_nxt = SETTLE;
            SETTLE:  if (settle_end) state_nxt = MEASURE;
            MEASURE: if (win_end)    state_nxt = NEXT;
            NEXT:    state_nxt = last_tap ? EVAL : SETTLE;
            EVAL:    if (fin_valid)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            hits     <= '0;
            // NOTE: the bitmap is a handful of flops and is reset, so a sweep cut short by rst leaves nothing behind.
            bitmap   <= '0;
            eval_go  <= 1'b0;
            tap_sel  <= TAP_W'(DEFAULT_TAP);
            cal_busy <= 1'b0;
            cal_done <= 1'b0;
            cal_fail <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here update from pre-edge values.
            cal_done <= 1'b0;
            eval_go  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cal_start) begin
                        tap_sel  <= '0;
                        bitmap   <= '0;
                        cal_busy <= 1'b1;
                        cnt      <= '0;
                        hits     <= '0;
                    end
                end
                SETTLE: begin
                    cnt <= settle_end ? '0 : cnt + CNT_W'(1);
                end
                MEASURE: begin
                    cnt <= win_end ? '0 : cnt + CNT_W'(1);
                    if (hit && (hits != HIT_W'(MIN_HITS))) hits <= hits + HIT_W'(1);
                end
                NEXT: begin
                    bitmap[tap_sel] <= (hits == HIT_W'(MIN_HITS));
                    hits            <= '0;
                    if (last_tap) eval_go <= 1'b1;
                    else          tap_sel <= tap_sel + TAP_W'(1);
                end
                DONE: begin
                    cal_done <= 1'b1;
                    cal_busy <= 1'b0;
                    if (fin_len == '0) begin
                        tap_sel  <= TAP_W'(DEFAULT_TAP);
                        cal_fail <= 1'b1;
                    end else begin
                        tap_sel  <= result_tap;
                        cal_fail <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MIPI_DLY_CAL_MAP_EN
    // Published bitmap: refreshed at the end of each calibration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                pass_map <= '0;
        else if (state == DONE) pass_map <= bitmap;
    end
`endif

endmodule

// File: tb/tb_mipi_dly_tap_cal.sv
// Scoreboard bench for mipi_dly_tap_cal (NUM_TAPS=8, SETTLE_CYC=16, WIN_CYC=256, MIN_HITS=4).
// The driver pushes the expected outcome when it issues cal_start. It then plays a
// channel whose sync bytes depend on the tap the bench expects to be measured at
// each point of its own timeline. The monitor pops and compares on every cal_done.
module tb_mipi_dly_tap_cal;

    localparam int NUM_TAPS = 8;
    localparam int PERIOD   = 16 + 256 + 1;
    localparam int LATENCY  = NUM_TAPS * PERIOD + NUM_TAPS + 2;
    localparam logic [7:0] SYNC = 8'hB8;

    logic       clk = 1'b0;
    logic       rst;
    logic       cal_start;
    logic [7:0] data_in;
    logic       data_vld;
    logic [2:0] tap_sel;
    logic       cal_busy;
    logic       cal_done;
    logic       cal_fail;
`ifdef MIPI_DLY_CAL_MAP_EN
    logic [7:0] pass_map;
`endif

    always #5 clk = ~clk;

    mipi_dly_tap_cal #(
        .NUM_TAPS    (8),
        .TAP_W       (3),
        .DEFAULT_TAP (4),
        .SETTLE_CYC  (16),
        .WIN_CYC     (256),
        .MIN_HITS    (4),
        .SYNC_BYTE   (8'hB8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cal_start (cal_start),
        .data_in   (data_in),
        .data_vld  (data_vld),
        .tap_sel   (tap_sel),
        .cal_busy  (cal_busy),
        .cal_done  (cal_done),
        .cal_fail  (cal_fail)
`ifdef MIPI_DLY_CAL_MAP_EN
        ,
        .pass_map  (pass_map)
`endif
    );

    typedef struct {
        int tap;
        int fail;
        int map;
        int done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cal_done must match the oldest outstanding expectation.
    exp_t got_e;
    always @(negedge clk) begin
        if (!rst && cal_done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                got_e = sb_q.pop_front();
                check("done_tap_sel", 32'(tap_sel), got_e.tap);
                check("done_cal_fail", 32'(cal_fail), got_e.fail);
                check("done_cal_busy", 32'(cal_busy), 0);
                check("done_latency", cyc, got_e.done_cyc);
`ifdef MIPI_DLY_CAL_MAP_EN
                check("done_pass_map", 32'(pass_map), got_e.map);
`endif
            end
        end
    end

    // Channel for the sample taken at edge p after cal_start (p >= 1).
    task automatic drive_data(input int p, input int hits[NUM_TAPS]);
        int k;
        int off;
        k        = (p - 1) / PERIOD;
        off      = (p - 1) % PERIOD;
        data_vld = 1'b1;
        case (p % 3)
            0:       data_in = 8'hB9;
            1:       data_in = 8'h38;
            default: data_in = 8'hB0;
        endcase
        if (k < NUM_TAPS) begin
            if (off == 5) data_in = SYNC;
            if (off >= 100 && off < 100 + hits[k]) data_in = SYNC;
            if (off == 150) begin
                data_in  = SYNC;
                data_vld = 1'b0;
            end
        end
    endtask

    // One full calibration with an expected outcome; optional stray cal_start mid-MEASURE at tap 3.
    task automatic run_cal(input int hits[NUM_TAPS], input int exp_tap, input int exp_fail,
                           input int exp_map, input bit poke_start);
        exp_t e;
        @(negedge clk);
        e.tap      = exp_tap;
        e.fail     = exp_fail;
        e.map      = exp_map;
        e.done_cyc = cyc + 1 + LATENCY;
        sb_q.push_back(e);
        cal_start = 1'b1;
        for (int c = 0; c < LATENCY + 4; c++) begin
            @(negedge clk);
            cal_start = poke_start && (c == 3 * PERIOD + 50);
            if (c == 0) check("busy_after_start", 32'(cal_busy), 1);
            drive_data(c + 1, hits);
        end
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    // rst during MEASURE of tap 2: outputs return to reset values and no cal_done follows.
    task automatic run_reset_abort();
        int h[NUM_TAPS];
        h = '{10, 10, 10, 10, 10, 10, 10, 10};
        @(negedge clk);
        cal_start = 1'b1;
        for (int c = 0; c < 2 * PERIOD + 100; c++) begin
            @(negedge clk);
            cal_start = 1'b0;
            drive_data(c + 1, h);
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_tap_sel", 32'(tap_sel), 4);
        check("abort_cal_busy", 32'(cal_busy), 0);
        check("abort_cal_done", 32'(cal_done), 0);
        check("abort_cal_fail", 32'(cal_fail), 0);
`ifdef MIPI_DLY_CAL_MAP_EN
        check("abort_pass_map", 32'(pass_map), 0);
`endif
        rst = 1'b0;
        for (int c = 0; c < LATENCY + 20; c++) begin
            @(negedge clk);
            drive_data(c + 1, h);
        end
        check("abort_idle_tap_sel", 32'(tap_sel), 4);
        check("abort_idle_busy", 32'(cal_busy), 0);
    endtask

    initial begin
        int h[NUM_TAPS];
        rst       = 1'b1;
        cal_start = 1'b0;
        data_vld  = 1'b0;
        data_in   = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tap_sel", 32'(tap_sel), 4);
        check("reset_cal_busy", 32'(cal_busy), 0);
        check("reset_cal_done", 32'(cal_done), 0);
        check("reset_cal_fail", 32'(cal_fail), 0);
`ifdef MIPI_DLY_CAL_MAP_EN
        check("reset_pass_map", 32'(pass_map), 0);
`endif
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_tap_sel", 32'(tap_sel), 4);
        check("idle_cal_busy", 32'(cal_busy), 0);

        // Centre pick: taps 2..5 pass -> 2 + (4-1)/2 = 3.
        h = '{0, 0, 10, 10, 10, 10, 0, 0};
        run_cal(h, 3, 0, 8'h3C, 1'b0);
        // No eye anywhere.
        h = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_cal(h, 4, 1, 8'h00, 1'b0);
        // Taps 6..7 clear the sticky fail -> 6 + (2-1)/2 = 6.
        h = '{0, 0, 0, 0, 0, 0, 10, 10};
        run_cal(h, 6, 0, 8'hC0, 1'b0);
        // Longest run 5..7 beats 0..1 -> 5 + 1 = 6.
        h = '{10, 10, 0, 0, 0, 10, 10, 10};
        run_cal(h, 6, 0, 8'hE3, 1'b0);
        // Tie 0..1 vs 4..5: lower start wins -> 0.
        h = '{10, 10, 0, 0, 10, 10, 0, 0};
        run_cal(h, 0, 0, 8'h33, 1'b0);
        // Threshold: 3 hits on tap 3 is not enough.
        h = '{0, 0, 0, 3, 0, 0, 0, 0};
        run_cal(h, 4, 1, 8'h00, 1'b0);
        // Threshold: exactly 4 hits on tap 3 passes.
        h = '{0, 0, 0, 4, 0, 0, 0, 0};
        run_cal(h, 3, 0, 8'h08, 1'b0);
        // Stray cal_start during MEASURE at tap 3 is ignored.
        h = '{0, 0, 10, 10, 10, 10, 0, 0};
        run_cal(h, 3, 0, 8'h3C, 1'b1);

        run_reset_abort();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
